// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl (with full_adder_4bit slice)
// Brief    : Wide add/subtract computed one nibble per clock through a single
//            4-bit ripple adder, with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================

module full_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = w_c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int N_NIBBLES = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           op_sub,
    input  logic                           cin,
    input  logic [4*N_NIBBLES-1:0]         a,
    input  logic [4*N_NIBBLES-1:0]         b,
    output logic                           busy,
    output logic                           done,
    output logic [4*N_NIBBLES-1:0]         sum,
    output logic                           cout,
    output logic                           overflow,
    output logic [$clog2(N_NIBBLES)-1:0]   nibble_idx
);
    localparam int W     = 4 * N_NIBBLES;
    localparam int IDX_W = $clog2(N_NIBBLES);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [W-1:0]     r_a_sh;
    logic [W-1:0]     r_b_sh;
    logic [W-1:0]     r_work;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [IDX_W-1:0] r_idx;

    logic [3:0]       w_nib_sum;
    logic             w_nib_cout;
    logic             w_last;
    logic [W-1:0]     w_work_next;

    full_adder_4bit u_slice (
        .a    (r_a_sh[3:0]),
        .b    (r_b_sh[3:0]),
        .cin  (r_carry),
        .sum  (w_nib_sum),
        .cout (w_nib_cout)
    );

    assign w_last      = (r_idx == C_LAST_IDX);
    assign w_work_next = {w_nib_sum, r_work[W-1:4]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Results are committed on the final RUN edge so they are valid in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= op_sub ? ~b : b;
                        r_carry <= op_sub ? 1'b1 : cin;
                        r_a_msb <= a[W-1];
                        r_b_msb <= op_sub ? ~b[W-1] : b[W-1];
                        r_work  <= '0;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh  <= {4'b0000, r_a_sh[W-1:4]};
                    r_b_sh  <= {4'b0000, r_b_sh[W-1:4]};
                    r_work  <= w_work_next;
                    r_carry <= w_nib_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sum  <= w_work_next;
                        r_cout <= w_nib_cout;
                        r_ovf  <= (r_a_msb == r_b_msb) && (w_work_next[W-1] != r_a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign sum        = r_sum;
    assign cout       = r_cout;
    assign overflow   = r_ovf;
    assign nibble_idx = (r_state == S_RUN) ? r_idx : '0;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Brief    : Directed self-checking bench for 16-bit and 8-bit configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        s4, op4, cin4, busy4, done4, cout4, ovf4;
    logic [15:0] a4, b4, sum4;
    logic [1:0]  idx4;

    logic        s2, op2, cin2, busy2, done2, cout2, ovf2;
    logic [7:0]  a2, b2, sum2;
    logic [0:0]  idx2;

    int checks = 0;
    int errors = 0;
    logic [15:0] prev_sum4;
    logic [15:0] ta [18];
    logic [15:0] tbv[18];
    logic        tc [18];

    nibble_serial_adder_ctrl #(.N_NIBBLES(4)) dut4 (
        .clock(clock), .reset(reset), .start(s4), .op_sub(op4), .cin(cin4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4),
        .cout(cout4), .overflow(ovf4), .nibble_idx(idx4)
    );

    nibble_serial_adder_ctrl #(.N_NIBBLES(2)) dut2 (
        .clock(clock), .reset(reset), .start(s2), .op_sub(op2), .cin(cin2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2),
        .cout(cout2), .overflow(ovf2), .nibble_idx(idx2)
    );

    task automatic test_reset();
        reset = 1'b1;
        s4 = 0; op4 = 0; cin4 = 0; a4 = 0; b4 = 0;
        s2 = 0; op2 = 0; cin2 = 0; a2 = 0; b2 = 0;
        #1;
        checks++;
        if (busy4 !== 0 || done4 !== 0 || sum4 !== 0 || cout4 !== 0 || ovf4 !== 0 || idx4 !== 0) begin
            errors++;
            $display("FAIL reset4: busy=%b done=%b sum=%h cout=%b ovf=%b idx=%0d, want all 0",
                     busy4, done4, sum4, cout4, ovf4, idx4);
        end
        checks++;
        if (busy2 !== 0 || done2 !== 0 || sum2 !== 0 || cout2 !== 0 || ovf2 !== 0 || idx2 !== 0) begin
            errors++;
            $display("FAIL reset2: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy2, done2, sum2, cout2, ovf2);
        end
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b0;
        prev_sum4 = 16'h0000;
    endtask

    task automatic run_op4(input logic sub, input logic ci, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] es, input logic ec, input logic eo, input string nm);
        op4 = sub; cin4 = ci; a4 = a; b4 = b; s4 = 1'b1;
        @(posedge clock); #1;
        s4 = 1'b0; a4 = ~a; b4 = a ^ b; op4 = ~sub; cin4 = ~ci;
        checks++;
        if (busy4 !== 1 || done4 !== 0 || idx4 !== 0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b idx=%0d, want 1 0 0", nm, busy4, done4, idx4);
        end
        for (int k = 1; k < 4; k++) begin
            @(posedge clock); #1;
            checks++;
            if (busy4 !== 1 || done4 !== 0 || idx4 !== 2'(k) || sum4 !== prev_sum4) begin
                errors++;
                $display("FAIL %s run%0d: busy=%b done=%b idx=%0d sum=%h, want 1 0 %0d %h",
                         nm, k, busy4, done4, idx4, sum4, k, prev_sum4);
            end
        end
        @(posedge clock); #1;
        checks++;
        if (done4 !== 1 || busy4 !== 1 || sum4 !== es || cout4 !== ec || ovf4 !== eo || idx4 !== 0) begin
            errors++;
            $display("FAIL %s done: done=%b busy=%b sum=%h cout=%b ovf=%b, want 1 1 %h %b %b",
                     nm, done4, busy4, sum4, cout4, ovf4, es, ec, eo);
        end
        @(posedge clock); #1;
        checks++;
        if (done4 !== 0 || busy4 !== 0 || sum4 !== es || cout4 !== ec || ovf4 !== eo) begin
            errors++;
            $display("FAIL %s after: done=%b busy=%b sum=%h cout=%b ovf=%b, want 0 0 %h %b %b",
                     nm, done4, busy4, sum4, cout4, ovf4, es, ec, eo);
        end
        prev_sum4 = es;
    endtask

    task automatic test_add();
        run_op4(0, 0, 16'h1234, 16'h0FCD, 16'h2201, 0, 0, "add_basic");
        run_op4(0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, "add_wrap");
        run_op4(0, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, "add_ovf");
        run_op4(0, 1, 16'h00FF, 16'h0F00, 16'h1000, 0, 0, "add_cin");
    endtask

    task automatic test_sub();
        run_op4(1, 1, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, "sub_neg");
        run_op4(1, 0, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, "sub_ovf");
    endtask

    task automatic test_back_to_back();
        logic [16:0] r;
        logic        eo;
        int          j;
        for (int k = 0; k < 18; k++) begin
            ta[k]  = 16'(32'h0F00 + k * 32'h0123);
            tbv[k] = 16'(32'hFFF0 - k * 32'h0311);
            tc[k]  = k[0];
            a4 = ta[k]; b4 = tbv[k]; cin4 = tc[k]; op4 = 1'b0; s4 = 1'b1;
            @(posedge clock); #1;
            checks++;
            if ((k % 6) == 4) begin
                j  = k - 4;
                r  = {1'b0, ta[j]} + {1'b0, tbv[j]} + {16'h0000, tc[j]};
                eo = (ta[j][15] == tbv[j][15]) && (r[15] != ta[j][15]);
                if (done4 !== 1 || sum4 !== r[15:0] || cout4 !== r[16] || ovf4 !== eo) begin
                    errors++;
                    $display("FAIL b2b edge%0d: done=%b sum=%h cout=%b ovf=%b, want 1 %h %b %b",
                             k, done4, sum4, cout4, ovf4, r[15:0], r[16], eo);
                end
                prev_sum4 = r[15:0];
            end else if (done4 !== 0) begin
                errors++;
                $display("FAIL b2b edge%0d: done=%b, want 0", k, done4);
            end
        end
        s4 = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (busy4 !== 0 || done4 !== 0) begin
            errors++;
            $display("FAIL b2b idle: busy=%b done=%b, want 0 0", busy4, done4);
        end
    endtask

    task automatic test_mid_reset();
        op4 = 0; cin4 = 0; a4 = 16'h4444; b4 = 16'h1111; s4 = 1'b1;
        @(posedge clock); #1;
        s4 = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (busy4 !== 0 || done4 !== 0 || sum4 !== 0 || cout4 !== 0 || ovf4 !== 0 || idx4 !== 0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b sum=%h cout=%b ovf=%b idx=%0d, want all 0",
                     busy4, done4, sum4, cout4, ovf4, idx4);
        end
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b0;
        prev_sum4 = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            checks++;
            if (done4 !== 0 || busy4 !== 0 || sum4 !== 0) begin
                errors++;
                $display("FAIL post_reset%0d: done=%b busy=%b sum=%h, want 0 0 0", k, done4, busy4, sum4);
            end
        end
        run_op4(0, 0, 16'h4444, 16'h1111, 16'h5555, 0, 0, "after_reset");
    endtask

    task automatic run_op2(input logic sub, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] es, input logic ec, input logic eo, input string nm);
        op2 = sub; cin2 = 1'b0; a2 = a; b2 = b; s2 = 1'b1;
        @(posedge clock); #1;
        s2 = 1'b0; a2 = 8'h00; b2 = 8'h00;
        checks++;
        if (busy2 !== 1 || done2 !== 0 || idx2 !== 1'b0) begin
            errors++;
            $display("FAIL %s run0: busy=%b done=%b idx=%0d, want 1 0 0", nm, busy2, done2, idx2);
        end
        @(posedge clock); #1;
        checks++;
        if (busy2 !== 1 || done2 !== 0 || idx2 !== 1'b1) begin
            errors++;
            $display("FAIL %s run1: busy=%b done=%b idx=%0d, want 1 0 1", nm, busy2, done2, idx2);
        end
        @(posedge clock); #1;
        checks++;
        if (done2 !== 1 || sum2 !== es || cout2 !== ec || ovf2 !== eo) begin
            errors++;
            $display("FAIL %s done: done=%b sum=%h cout=%b ovf=%b, want 1 %h %b %b",
                     nm, done2, sum2, cout2, ovf2, es, ec, eo);
        end
        @(posedge clock); #1;
        checks++;
        if (done2 !== 0 || busy2 !== 0) begin
            errors++;
            $display("FAIL %s after: done=%b busy=%b, want 0 0", nm, done2, busy2);
        end
    endtask

    task automatic test_n2();
        run_op2(0, 8'hF0, 8'h10, 8'h00, 1, 0, "n2_wrap");
        run_op2(1, 8'h10, 8'h20, 8'hF0, 0, 0, "n2_sub");
        run_op2(0, 8'h70, 8'h10, 8'h80, 0, 1, "n2_ovf");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_mid_reset();
        test_n2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
